if_pc_fetch: RTL and testbench

//  Program-counter register and instruction-fetch sequencer of the MIPS IF stage.

---
 rtl/mips_if_pkg.sv | 16 +
 rtl/if_pc_fetch.sv | 126 ++++++++++++
 tb/tb_if_pc_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_if_pkg.sv
// Shared constants and state encoding for the MIPS IF-stage fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_if_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 32;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_pc_fetch.sv
// PC register plus fetch sequencer: requests imem, lands each word in the IF/ID latch.
// Latency: a fetched word is visible on ifid_* the cycle after its imem ack.
// Backpressure: one skid entry absorbs an ack while ID stalls; fetch pauses (HOLD) until ID drains.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   pc_plus1_o / next_pc_i  pc+1 to the external next-PC mux, mux result back as next PC
//   flush_i                 branch redirect; kills in-flight and latched fetches
//   imem_req_o/addr_o       fetch request, address stable while request is high
//   imem_ack_i/data_i       single-cycle memory response
//   ifid_valid/instr/npc_o  IF/ID latch contents
//   id_ready_i              ID accepts the latch this cycle
module if_pc_fetch
    import mips_if_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  pc_plus1_o,
    input  logic [ADDR_W-1:0]  next_pc_i,
    input  logic               flush_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic               ifid_valid_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic [ADDR_W-1:0]  ifid_npc_o,
    input  logic               id_ready_i
);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_npc;
    // Set when a flush lands while a request is still outstanding: the ack
    // that eventually answers it belongs to the wrong path and must be dropped.
    logic               kill;

    logic               latch_free;
    logic [ADDR_W-1:0]  fetch_npc;

    assign pc_plus1_o = pc + ADDR_W'(1);
    assign imem_req_o = (state == ST_REQ);
    assign latch_free = !ifid_valid_o || id_ready_i;
    assign fetch_npc  = imem_addr_o + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pc           <= RESET_PC;
            imem_addr_o  <= '0;
            ifid_valid_o <= 1'b0;
            ifid_instr_o <= '0;
            ifid_npc_o   <= '0;
            skid_instr   <= '0;
            skid_npc     <= '0;
            kill         <= 1'b0;
        end else if (flush_i) begin
            // Redirect wins over everything, including an ID transfer this cycle.
            pc           <= next_pc_i;
            ifid_valid_o <= 1'b0;
            skid_instr   <= '0;
            skid_npc     <= '0;
            if (state == ST_REQ) begin
                if (imem_ack_i) begin
                    // Outstanding word arrives now and is dropped; request the target.
                    imem_addr_o <= next_pc_i;
                    kill        <= 1'b0;
                end else begin
                    // Address must stay put until the old request is answered.
                    kill <= 1'b1;
                end
            end else begin
                state       <= ST_REQ;
                imem_addr_o <= next_pc_i;
                kill        <= 1'b0;
            end
        end else begin
            // ID draining the latch with nothing new arriving empties it;
            // the branches below override this when a word moves in.
            if (ifid_valid_o && id_ready_i) begin
                ifid_valid_o <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    state       <= ST_REQ;
                    imem_addr_o <= pc;
                end
                ST_REQ: begin
                    if (imem_ack_i) begin
                        if (kill) begin
                            kill        <= 1'b0;
                            imem_addr_o <= pc;
                        end else if (latch_free) begin
                            ifid_instr_o <= imem_data_i;
                            ifid_npc_o   <= fetch_npc;
                            ifid_valid_o <= 1'b1;
                            pc           <= next_pc_i;
                            imem_addr_o  <= next_pc_i;
                        end else begin
                            skid_instr <= imem_data_i;
                            skid_npc   <= fetch_npc;
                            pc         <= next_pc_i;
                            state      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (id_ready_i) begin
                        ifid_instr_o <= skid_instr;
                        ifid_npc_o   <= skid_npc;
                        ifid_valid_o <= 1'b1;
                        imem_addr_o  <= pc;
                        state        <= ST_REQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_pc_fetch.sv
module tb_if_pc_fetch;
    import mips_if_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int IW = DEF_INSTR_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] pc_plus1;
    logic [AW-1:0] next_pc;
    logic          flush = 1'b0;
    logic [AW-1:0] flush_tgt = '0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [IW-1:0] imem_data = '0;
    logic          ifid_valid;
    logic [IW-1:0] ifid_instr;
    logic [AW-1:0] ifid_npc;
    logic          id_ready = 1'b0;

    // External next-PC mux: sequential path or branch target.
    assign next_pc = flush ? flush_tgt : pc_plus1;

    always #5 clk = ~clk;

    if_pc_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_plus1_o   (pc_plus1),
        .next_pc_i    (next_pc),
        .flush_i      (flush),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ack_i   (imem_ack),
        .imem_data_i  (imem_data),
        .ifid_valid_o (ifid_valid),
        .ifid_instr_o (ifid_instr),
        .ifid_npc_o   (ifid_npc),
        .id_ready_i   (id_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return {8'hA5, a, ~a, a ^ 8'h3C};
    endfunction

    // Memory responder state
    bit            pending = 0;
    logic [AW-1:0] paddr = '0;
    int            cnt = 0;
    int            fixed_delay = 1;

    // Reference model: the program-order address stream ID should receive.
    logic [AW-1:0] exp_addr = DEF_RESET_PC;
    int            n_deliv = 0;
    bit            post_flush = 0;
    bit            chk_tgt = 0;
    logic [AW-1:0] last_tgt = '0;
    bit            flush_on_ack = 0;

    task automatic step(input int ready_pct, input int flush_pct,
                        input bit force_flush, input logic [AW-1:0] ftgt);
        logic [AW-1:0] e_npc;
        bit            targeted;
        @(negedge clk);
        if (post_flush) begin
            check_eq("flush_clears_latch", ifid_valid, 0);
            if (chk_tgt) begin
                check_eq("flush_ack_req", imem_req, 1);
                check_eq("flush_ack_addr", imem_addr, last_tgt);
            end
            post_flush = 0;
            chk_tgt = 0;
        end
        // memory: answer each request 'delay' cycles after first seeing it
        imem_ack = 1'b0;
        if (pending) begin
            cnt--;
            if (cnt == 0) begin
                imem_ack  = 1'b1;
                imem_data = mem_word(paddr);
                pending   = 0;
            end
        end else if (imem_req) begin
            pending = 1;
            paddr   = imem_addr;
            cnt     = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 3));
        end
        id_ready = ($urandom_range(0, 99) < ready_pct);
        targeted = force_flush || (flush_on_ack && imem_ack);
        flush    = targeted || ($urandom_range(0, 99) < flush_pct);
        if (flush) begin
            flush_tgt = targeted ? ftgt : AW'($urandom);
            exp_addr  = flush_tgt;
            last_tgt  = flush_tgt;
            post_flush = 1;
            chk_tgt   = imem_ack;
            if (flush_on_ack && imem_ack) flush_on_ack = 0;
        end else if (ifid_valid && id_ready) begin
            e_npc = exp_addr + 1'b1;
            check_eq("ifid_npc", ifid_npc, e_npc);
            check_eq("ifid_instr", ifid_instr, mem_word(exp_addr));
            exp_addr = exp_addr + 1'b1;
            n_deliv++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"}, imem_req, 0);
        check_eq({tag, "_addr"}, imem_addr, 0);
        check_eq({tag, "_valid"}, ifid_valid, 0);
        check_eq({tag, "_instr"}, ifid_instr, 0);
        check_eq({tag, "_npc"}, ifid_npc, 0);
        check_eq({tag, "_pc1"}, pc_plus1, DEF_RESET_PC + 8'h01);
    endtask

    initial begin
        int  n0;
        bit  found;

        // ---- 1: reset and steady streaming, ack every 2nd cycle
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        exp_addr = DEF_RESET_PC;
        fixed_delay = 1;
        step(100, 0, 0, '0);
        check_eq("t1_first_req", imem_req, 1);
        check_eq("t1_first_addr", imem_addr, DEF_RESET_PC);
        n0 = n_deliv;
        repeat (20) step(100, 0, 0, '0);
        check_eq("t1_rate", (n_deliv - n0) >= 8, 1);

        // ---- 2: ID stall fills latch + skid, fetch must pause
        repeat (12) step(0, 0, 0, '0);
        check_eq("t2_hold_req", imem_req, 0);
        check_eq("t2_hold_valid", ifid_valid, 1);
        n0 = n_deliv;
        repeat (12) step(100, 0, 0, '0);
        check_eq("t2_release", (n_deliv - n0) >= 4, 1);

        // ---- 3: flush while request @05 outstanding
        fixed_delay = 3;
        step(100, 0, 1, 8'h03);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step(100, 0, 0, '0);
            if (pending && paddr == 8'h05 && cnt == 3) found = 1;
        end
        check_eq("t3_seen_req05", found, 1);
        step(100, 0, 1, 8'h40);
        step(100, 0, 0, '0);
        check_eq("t3_req_held", imem_req, 1);
        check_eq("t3_addr_held", imem_addr, 8'h05);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(100, 0, 0, '0);
            if (ifid_valid) found = 1;
        end
        check_eq("t3_seen_word", found, 1);
        check_eq("t3_npc", ifid_npc, 8'h41);

        // ---- 4: flush in the same cycle as an ack with ID ready
        fixed_delay = 1;
        flush_on_ack = 1;
        for (int i = 0; i < 20 && flush_on_ack; i++) step(100, 0, 0, 8'h80);
        check_eq("t4_flush_done", flush_on_ack, 0);
        flush_on_ack = 0;
        step(100, 0, 0, '0);

        // ---- 5: address wrap at 8'hFF
        step(100, 0, 1, 8'hFC);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(100, 0, 0, '0);
            if (imem_req && imem_addr == 8'hFF) found = 1;
        end
        check_eq("t5_seen_ff", found, 1);
        check_eq("t5_pc_plus1", pc_plus1, 8'h00);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(100, 0, 0, '0);
            if (ifid_valid && ifid_npc == 8'h00) found = 1;
        end
        check_eq("t5_seen_npc00", found, 1);
        check_eq("t5_next_addr", imem_addr, 8'h00);

        // ---- random traffic: stalls, variable latency, branches
        fixed_delay = 0;
        n0 = n_deliv;
        repeat (1500) step(70, 3, 0, '0);
        check_eq("rand_progress", (n_deliv - n0) >= 150, 1);

        // ---- 6: reset in the middle of a request, late ack ignored
        fixed_delay = 3;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(100, 0, 0, '0);
            if (pending) found = 1;
        end
        check_eq("t6_seen_req", found, 1);
        @(negedge clk);
        flush = 1'b0;
        rst_n = 1'b0;
        imem_ack = 1'b1;
        imem_data = 32'hDEADBEEF;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        rst_n = 1'b1;           // ack still high through the first IDLE cycle
        pending = 0;
        post_flush = 0;
        exp_addr = DEF_RESET_PC;
        n0 = n_deliv;
        step(100, 0, 0, '0);
        check_eq("t6_restart_addr", imem_addr, DEF_RESET_PC);
        repeat (30) step(100, 0, 0, '0);
        check_eq("t6_progress", (n_deliv - n0) >= 5, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
